// File: rtl/regfile_mp.sv
// regfile_mp: parametrised register file with one byte-enabled write port,
// two registered read ports with same-cycle write bypass, and a sequential
// soft-clear engine that walks every entry once.

// One registered read port. It looks up the entry, merges any same-cycle
// write to the same address, and forces zero while a clear is running.
module regfile_rdport #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic [ADDR_W-1:0]             addr,
    input  logic [DEPTH-1:0][DATA_W-1:0]  mem,
    input  logic                          blank,
    input  logic                          wr_ok,
    input  logic [ADDR_W-1:0]             wr_addr,
    input  logic [DATA_W-1:0]             wr_mask,
    input  logic [DATA_W-1:0]             wr_data,
    output logic [DATA_W-1:0]             data,
    output logic                          valid
);

    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);

    logic              in_range;
    logic [DATA_W-1:0] word;

    assign in_range = ({1'b0, addr} < DEPTH_X);

    // Select the stored word, overlay the committing write's enabled bytes.
    always_comb begin
        word = '0;
        if (!blank && in_range) begin
            word = mem[addr];
            if (wr_ok && (wr_addr == addr))
                word = (word & ~wr_mask) | (wr_data & wr_mask);
        end
    end

    // Output register: valid tracks the request, data holds when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data  <= '0;
            valid <= 1'b0;
        end else begin
            valid <= en;
            if (en)
                data <= word;
        end
    end

endmodule

module regfile_mp #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_W/8-1:0]   wr_be,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic                  rd0_en,
    input  logic [ADDR_W-1:0]     rd0_addr,
    output logic [DATA_W-1:0]     rd0_data,
    output logic                  rd0_valid,
    input  logic                  rd1_en,
    input  logic [ADDR_W-1:0]     rd1_addr,
    output logic [DATA_W-1:0]     rd1_data,
    output logic                  rd1_valid,
    input  logic                  clr,
    output logic                  busy
);

    localparam int              NB      = DATA_W / 8;
    localparam int              NUM_RD  = 2;
    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    typedef struct packed {
        logic              en;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] mask;
        logic [DATA_W-1:0] data;
    } wr_req_t;

    logic [DEPTH-1:0][DATA_W-1:0]  mem;
    logic [0:0]                    state;
    logic [ADDR_W-1:0]             ptr;
    wr_req_t                       wreq;
    logic [DATA_W-1:0]             wr_merged;
    logic                          blank;

    logic [NUM_RD-1:0]              rd_en;
    logic [NUM_RD-1:0][ADDR_W-1:0]  rd_addr;
    logic [NUM_RD-1:0][DATA_W-1:0]  rd_data;
    logic [NUM_RD-1:0]              rd_valid;

    assign blank = (state == ST_CLEAR);

    // Build the write request; it only commits when idle, in range, and
    // not colliding with a clear request (clear takes priority).
    always_comb begin
        wreq      = '0;
        wreq.addr = wr_addr;
        wreq.data = wr_data;
        for (int b = 0; b < NB; b++)
            wreq.mask[8*b +: 8] = {8{wr_be[b]}};
        wreq.en = wr_en && (state == ST_IDLE) && !clr && ({1'b0, wr_addr} < DEPTH_X);
    end

    // Read-modify-write merge of the enabled bytes into the stored word.
    always_comb begin
        wr_merged = '0;
        if (wreq.en)
            wr_merged = (mem[wreq.addr] & ~wreq.mask) | (wreq.data & wreq.mask);
    end

    // Storage, write port and the clear sequencer share one state block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem   <= '0;
            state <= ST_IDLE;
            ptr   <= '0;
            busy  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (clr) begin
                        state <= ST_CLEAR;
                        ptr   <= '0;
                        busy  <= 1'b1;
                    end else if (wreq.en) begin
                        mem[wreq.addr] <= wr_merged;
                    end
                end
                ST_CLEAR: begin
                    mem[ptr] <= '0;
                    if (ptr == LAST) begin
                        state <= ST_IDLE;
                        ptr   <= '0;
                        busy  <= 1'b0;
                    end else begin
                        ptr <= ptr + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    ptr   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign rd_en   = {rd1_en, rd0_en};
    assign rd_addr = {rd1_addr, rd0_addr};

    // One identical read port per lane.
    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        regfile_rdport #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH),
            .ADDR_W (ADDR_W)
        ) u_rd (
            .clk     (clk),
            .rst_n   (rst_n),
            .en      (rd_en[p]),
            .addr    (rd_addr[p]),
            .mem     (mem),
            .blank   (blank),
            .wr_ok   (wreq.en),
            .wr_addr (wreq.addr),
            .wr_mask (wreq.mask),
            .wr_data (wreq.data),
            .data    (rd_data[p]),
            .valid   (rd_valid[p])
        );
    end

    assign rd0_data  = rd_data[0];
    assign rd0_valid = rd_valid[0];
    assign rd1_data  = rd_data[1];
    assign rd1_valid = rd_valid[1];

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed scenarios plus randomized
// traffic checked against an array-based reference model.
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_addr = '0;
    logic [3:0]  wr_be = '0;
    logic [31:0] wr_data = '0;
    logic        rd0_en = 1'b0;
    logic [3:0]  rd0_addr = '0;
    logic [31:0] rd0_data;
    logic        rd0_valid;
    logic        rd1_en = 1'b0;
    logic [3:0]  rd1_addr = '0;
    logic [31:0] rd1_data;
    logic        rd1_valid;
    logic        clr = 1'b0;
    logic        busy;

    int checks = 0;
    int failures = 0;

    // Reference model state
    logic [31:0] mem_m [16];
    int          busy_cnt;
    logic [31:0] e0, e1;
    logic        ev0, ev1, eb;

    regfile_mp #(.DATA_W(32), .DEPTH(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
        .rd0_en(rd0_en), .rd0_addr(rd0_addr), .rd0_data(rd0_data), .rd0_valid(rd0_valid),
        .rd1_en(rd1_en), .rd1_addr(rd1_addr), .rd1_data(rd1_data), .rd1_valid(rd1_valid),
        .clr(clr), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) mem_m[i] = '0;
        busy_cnt = 0;
        e0 = '0; e1 = '0; ev0 = 1'b0; ev1 = 1'b0; eb = 1'b0;
    endtask

    task automatic idle_inputs();
        wr_en = 1'b0; wr_be = '0; rd0_en = 1'b0; rd1_en = 1'b0; clr = 1'b0;
    endtask

    // Apply current inputs for one clock edge and advance the model.
    task automatic tick();
        logic        busy_now, wacc;
        logic [31:0] wword;
        busy_now = (busy_cnt > 0);
        wacc  = wr_en && !busy_now && !clr;
        wword = merge(mem_m[wr_addr], wr_data, wr_be);
        ev0 = rd0_en;
        ev1 = rd1_en;
        if (rd0_en) e0 = busy_now ? 32'h0 : ((wacc && wr_addr == rd0_addr) ? wword : mem_m[rd0_addr]);
        if (rd1_en) e1 = busy_now ? 32'h0 : ((wacc && wr_addr == rd1_addr) ? wword : mem_m[rd1_addr]);
        @(posedge clk);
        #1;
        if (wacc) mem_m[wr_addr] = wword;
        if (!busy_now && clr) begin
            busy_cnt = 16;
            for (int i = 0; i < 16; i++) mem_m[i] = '0;
        end else if (busy_now) begin
            busy_cnt--;
        end
        eb = (busy_cnt > 0);
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        model_reset();
        #13;
        checks++;
        if (rd0_data !== 32'h0 || rd1_data !== 32'h0 || rd0_valid !== 1'b0 ||
            rd1_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: rd0=%h rd1=%h v0=%b v1=%b busy=%b, want all 0",
                     rd0_data, rd1_data, rd0_valid, rd1_valid, busy);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int a = 0; a < 16; a++) begin
            rd0_en = 1'b1; rd0_addr = 4'(a);
            rd1_en = 1'b1; rd1_addr = 4'(15 - a);
            tick();
            checks++;
            if (rd0_data !== 32'h0 || rd1_data !== 32'h0 || rd0_valid !== 1'b1 || rd1_valid !== 1'b1) begin
                failures++;
                $display("FAIL reset_read a=%0d: rd0=%h rd1=%h v0=%b v1=%b, want 0/0/1/1",
                         a, rd0_data, rd1_data, rd0_valid, rd1_valid);
            end
        end
        idle_inputs();
        tick();
        checks++;
        if (rd0_valid !== 1'b0 || rd1_valid !== 1'b0) begin
            failures++;
            $display("FAIL valid_drop: v0=%b v1=%b, want 0", rd0_valid, rd1_valid);
        end
    endtask

    task automatic test_byte_write();
        idle_inputs();
        wr_en = 1'b1; wr_addr = 4'd3; wr_be = 4'hF; wr_data = 32'hDEADBEEF;
        tick();
        wr_be = 4'b0101; wr_data = 32'h11223344;
        tick();
        idle_inputs();
        rd0_en = 1'b1; rd0_addr = 4'd3;
        tick();
        checks++;
        if (rd0_data !== 32'hDE22BE44 || rd0_valid !== 1'b1) begin
            failures++;
            $display("FAIL byte_write: rd0=%h v=%b, want DE22BE44 v=1", rd0_data, rd0_valid);
        end
        idle_inputs();
        rd1_en = 1'b1; rd1_addr = 4'd3;
        tick();
        checks++;
        if (rd1_data !== 32'hDE22BE44 || rd0_data !== 32'hDE22BE44 || rd0_valid !== 1'b0) begin
            failures++;
            $display("FAIL hold_data: rd0=%h rd1=%h v0=%b, want DE22BE44 DE22BE44 0",
                     rd0_data, rd1_data, rd0_valid);
        end
    endtask

    task automatic test_bypass();
        idle_inputs();
        wr_en = 1'b1; wr_addr = 4'd5; wr_be = 4'hF; wr_data = 32'hCAFEF00D;
        rd0_en = 1'b1; rd0_addr = 4'd5;
        rd1_en = 1'b1; rd1_addr = 4'd5;
        tick();
        checks++;
        if (rd0_data !== 32'hCAFEF00D || rd1_data !== 32'hCAFEF00D) begin
            failures++;
            $display("FAIL bypass_full: rd0=%h rd1=%h, want CAFEF00D", rd0_data, rd1_data);
        end
        wr_be = 4'b1000; wr_data = 32'h77000000;
        tick();
        checks++;
        if (rd0_data !== 32'h77FEF00D || rd1_data !== 32'h77FEF00D) begin
            failures++;
            $display("FAIL bypass_partial: rd0=%h rd1=%h, want 77FEF00D", rd0_data, rd1_data);
        end
        idle_inputs();
    endtask

    task automatic test_clear();
        idle_inputs();
        for (int a = 0; a < 16; a++) begin
            wr_en = 1'b1; wr_addr = 4'(a); wr_be = 4'hF; wr_data = 32'(a) * 32'h01010101;
            tick();
        end
        idle_inputs();
        rd0_en = 1'b1; rd0_addr = 4'd9;
        tick();
        checks++;
        if (rd0_data !== 32'h09090909) begin
            failures++;
            $display("FAIL fill: rd0=%h, want 09090909", rd0_data);
        end
        idle_inputs();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL clr_start: busy=%b, want 1", busy);
        end
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'(($urandom % 2)); wr_addr = 4'($urandom); wr_be = 4'hF; wr_data = $urandom | 32'h1;
            clr = (i == 5);
            rd0_en = 1'(($urandom % 2)); rd0_addr = 4'($urandom);
            rd1_en = 1'b1;               rd1_addr = 4'($urandom);
            tick();
            checks++;
            if (busy !== (i < 15) || rd0_valid !== ev0 || rd1_data !== 32'h0 ||
                (ev0 && rd0_data !== 32'h0)) begin
                failures++;
                $display("FAIL clear_cycle %0d: busy=%b rd0=%h v0=%b rd1=%h, want busy=%b v0=%b data 0",
                         i, busy, rd0_data, rd0_valid, rd1_data, (i < 15), ev0);
            end
        end
        idle_inputs();
        for (int a = 0; a < 16; a++) begin
            rd0_en = 1'b1; rd0_addr = 4'(a);
            rd1_en = 1'b1; rd1_addr = 4'(a);
            tick();
            checks++;
            if (rd0_data !== 32'h0 || rd1_data !== 32'h0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL after_clear a=%0d: rd0=%h rd1=%h busy=%b, want 0", a, rd0_data, rd1_data, busy);
            end
        end
        idle_inputs();
    endtask

    task automatic test_clr_with_write();
        idle_inputs();
        wr_en = 1'b1; wr_addr = 4'd2; wr_be = 4'hF; wr_data = 32'hAA;
        tick();
        wr_data = 32'h55; clr = 1'b1;
        tick();
        idle_inputs();
        for (int i = 0; i < 16; i++) tick();
        rd0_en = 1'b1; rd0_addr = 4'd2;
        tick();
        checks++;
        if (rd0_data !== 32'h0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL clr_wins: rd0=%h busy=%b, want 0 0", rd0_data, busy);
        end
        // first write is accepted right after busy falls
        idle_inputs();
        wr_en = 1'b1; wr_addr = 4'd2; wr_be = 4'hF; wr_data = 32'h1234ABCD;
        rd0_en = 1'b1; rd0_addr = 4'd2;
        tick();
        checks++;
        if (rd0_data !== 32'h1234ABCD) begin
            failures++;
            $display("FAIL write_after_clear: rd0=%h, want 1234ABCD", rd0_data);
        end
        idle_inputs();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            wr_en    = 1'(($urandom % 3) != 0);
            wr_addr  = 4'($urandom);
            wr_be    = 4'($urandom);
            wr_data  = $urandom;
            rd0_en   = 1'(($urandom % 4) != 0);
            rd0_addr = ($urandom % 3 == 0) ? wr_addr : 4'($urandom);
            rd1_en   = 1'(($urandom % 4) != 0);
            rd1_addr = ($urandom % 3 == 0) ? rd0_addr : 4'($urandom);
            clr      = (($urandom % 60) == 0);
            tick();
            checks++;
            if (rd0_data !== e0 || rd0_valid !== ev0 || rd1_data !== e1 ||
                rd1_valid !== ev1 || busy !== eb) begin
                failures++;
                $display("FAIL random %0d: rd0=%h/%b rd1=%h/%b busy=%b, want %h/%b %h/%b %b",
                         n, rd0_data, rd0_valid, rd1_data, rd1_valid, busy, e0, ev0, e1, ev1, eb);
            end
        end
        idle_inputs();
        while (busy_cnt > 0) tick();
    endtask

    task automatic test_async_reset_midclear();
        logic [31:0] v;
        idle_inputs();
        wr_en = 1'b1; wr_addr = 4'd4; wr_be = 4'hF; wr_data = 32'hA5A5A5A5;
        tick();
        idle_inputs();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        rd0_en = 1'b1; rd0_addr = 4'd4;
        for (int i = 0; i < 7; i++) tick();
        checks++;
        if (busy !== 1'b1 || rd0_valid !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset: busy=%b v0=%b, want 1 1", busy, rd0_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || rd0_valid !== 1'b0 || rd0_data !== 32'h0) begin
            failures++;
            $display("FAIL async_reset: busy=%b v0=%b rd0=%h, want 0 0 0", busy, rd0_valid, rd0_data);
        end
        idle_inputs();
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        v = $urandom;
        wr_en = 1'b1; wr_addr = 4'd0; wr_be = 4'hF; wr_data = v;
        tick();
        idle_inputs();
        rd0_en = 1'b1; rd0_addr = 4'd0;
        rd1_en = 1'b1; rd1_addr = 4'd4;
        tick();
        checks++;
        if (rd0_data !== v || rd1_data !== 32'h0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL post_reset: rd0=%h rd1=%h busy=%b, want %h 0 0", rd0_data, rd1_data, busy, v);
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_byte_write();
        test_bypass();
        test_clear();
        test_clr_with_write();
        test_random();
        test_async_reset_midclear();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
